shift_scheduler_32bit: RTL and testbench

Sequencing and arbitration front-end for the 32-bit shift datapath. Two requesters share one shift engine. Each request carries an opcode, operand X and shift amount Y. The block arbitrates round-robin, captures the operands, computes the result in a dedicated execute cycle, and holds a tagged response until the consumer accepts it. It sits between the ALU issue logic and the shift unit, so the shifter is never driven by more than one requester at a time.

---
 rtl/shift_scheduler_32bit.sv | 147 ++++++++++++++
 tb/tb_shift_scheduler_32bit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_scheduler_32bit.sv
// shift_scheduler_32bit: round-robin front-end for the 32-bit shift engine.
// Two requesters share one shifter. A request is captured in IDLE, the
// result is computed and registered in EXEC, and a tagged response is held
// in RESP until the consumer accepts it.
//
// Handshake rules (all channels): a transfer happens on a rising clk edge
// where valid && ready are both high. Ready is combinational from valid and
// the FSM state; valid never depends on ready. The response channel holds
// resp_id / resp_Z stable for as long as resp_valid is high and resp_ready
// is low.
module shift_scheduler_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_X,
  input  logic [31:0] req0_Y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_X,
  input  logic [31:0] req1_Y,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_Z
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_SRL  = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] x_q, x_d;
  logic [31:0] y_q, y_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] z_q, z_d;

  logic        any_valid;
  logic        grant_id;
  logic        amt_oob;
  logic [4:0]  amt;
  logic [31:0] shift_res;

  // Round-robin winner: on contention the requester not granted last time
  // wins; a lone requester wins regardless of history.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Shift datapath on the captured operands. A negative amount (Y[31]) or
  // any magnitude of 32 or more is out of range.
  always_comb begin
    amt_oob   = y_q[31] | (|y_q[30:5]);
    amt       = y_q[4:0];
    shift_res = x_q;
    case (op_q)
      OP_SRL:  shift_res = amt_oob ? 32'd0 : (x_q >> amt);
      OP_SLL:  shift_res = amt_oob ? 32'd0 : (x_q << amt);
      OP_SRA:  shift_res = amt_oob ? {32{x_q[31]}}
                                   : 32'($signed(x_q) >>> amt);
      default: shift_res = x_q;
    endcase
  end

  // FSM next-state, capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    z_d          = z_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    resp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          req0_ready   = ~grant_id;
          req1_ready   = grant_id;
          op_d         = grant_id ? req1_op : req0_op;
          x_d          = grant_id ? req1_X  : req0_X;
          y_d          = grant_id ? req1_Y  : req0_Y;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        z_d     = shift_res;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset; reset discards any
  // in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 2'b00;
      x_q          <= 32'd0;
      y_q          <= 32'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      z_q          <= 32'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      x_q          <= x_d;
      y_q          <= y_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      z_q          <= z_d;
    end
  end

  assign resp_id = id_q;
  assign resp_Z  = z_q;

endmodule

// File: tb/tb_shift_scheduler_32bit.sv
// Bench for shift_scheduler_32bit: directed cases, round-robin and
// backpressure scenarios, reset during EXEC, then randomized traffic.
// A negedge monitor keeps the expected response queue and a model of
// which requester must be ready.
module tb_shift_scheduler_32bit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
  logic [31:0] req0_X = '0, req0_Y = '0, req1_X = '0, req1_Y = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [31:0] resp_Z;

  shift_scheduler_32bit dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_X     (req0_X),
    .req0_Y     (req0_Y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_X     (req1_X),
    .req1_Y     (req1_Y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_Z     (resp_Z)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];   // {id, Z}
  int          acc_q[$];   // acceptance edge index per outstanding request
  logic model_last = 1'b1;
  logic rv_prev = 1'b0;
  logic rst_prev = 1'b0;
  logic exp_r0, exp_r1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: shift amount is 255 when negative, else the full
  // unsigned value; anything >= 32 is out of range.
  function automatic logic [31:0] ref_shift(input logic [1:0] op,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint unsigned s;
    logic [31:0] ones;
    logic [31:0] r;
    ones = 32'hFFFF_FFFF;
    s = y[31] ? 64'd255 : {32'd0, y};
    r = x;
    case (op)
      2'b00: r = (s >= 32) ? 32'd0 : (x >> s);
      2'b01: r = (s >= 32) ? 32'd0 : (x << s);
      2'b10: begin
        if (s >= 32) r = x[31] ? ones : 32'd0;
        else begin
          r = x >> s;
          if (x[31]) r = r | ~(ones >> s);
        end
      end
      default: r = x;
    endcase
    return r;
  endfunction

  // ---------------- monitor ----------------
  // Checks readies against an idle/round-robin model, compares each held
  // response with the queue head, and pushes expectations on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      model_last = 1'b1;
    end else begin
      if (rst_prev) begin
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_id", resp_id, 0);
        check("reset_resp_Z", resp_Z, 0);
      end
      exp_r0 = (exp_q.size() == 0) && req0_valid && (!req1_valid || model_last == 1'b1);
      exp_r1 = (exp_q.size() == 0) && req1_valid && (!req0_valid || model_last == 1'b0);
      check("req0_ready", req0_ready, exp_r0);
      check("req1_ready", req1_ready, exp_r1);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_resp: got resp_valid=1 id=%0d Z=%0h expected no response (cycle %0d)",
                   resp_id, resp_Z, cyc);
        end else begin
          check("resp_id", resp_id, exp_q[0][32]);
          check("resp_Z", resp_Z, exp_q[0][31:0]);
          if (!rv_prev) check("resp_latency", cyc, acc_q[0] + 1);
          if (resp_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (req0_valid && req0_ready) begin
        exp_q.push_back({1'b0, ref_shift(req0_op, req0_X, req0_Y)});
        acc_q.push_back(cyc + 1);
        model_last = 1'b0;
      end else if (req1_valid && req1_ready) begin
        exp_q.push_back({1'b1, ref_shift(req1_op, req1_X, req1_Y)});
        acc_q.push_back(cyc + 1);
        model_last = 1'b1;
      end
    end
    rv_prev  = resp_valid;
    rst_prev = rst;
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_y();
    case ($urandom_range(0, 5))
      0: return $urandom();
      1: return 32'hFFFF_FFFF - $urandom_range(0, 3);
      2: return 32'h7FFF_FFFF;
      3: return 32'd31 + $urandom_range(0, 2);
      default: return $urandom_range(0, 40);
    endcase
  endfunction

  task automatic rand_req(input logic id);
    if (id) begin
      req1_op = 2'($urandom_range(0, 3)); req1_X = $urandom(); req1_Y = rand_y();
    end else begin
      req0_op = 2'($urandom_range(0, 3)); req0_X = $urandom(); req0_Y = rand_y();
    end
  endtask

  task automatic issue(input logic id, input logic [1:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    bit done;
    done = 0;
    if (id) begin
      req1_op = op; req1_X = x; req1_Y = y; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_X = x; req0_Y = y; req0_valid = 1'b1;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) done = 1;
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no ready for requester %0d expected acceptance within 60 cycles", id);
    end
  endtask

  task automatic wait_idle();
    resp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_valid) break;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [1:0]  op_t[8];
  logic [31:0] x_t[8];
  logic [31:0] y_t[8];
  logic a0, a1, d0, d1;
  int accepts, last_acc;

  initial begin
    op_t[0] = 2'b00; x_t[0] = 32'h8000_0000; y_t[0] = 32'd4;
    op_t[1] = 2'b10; x_t[1] = 32'h8000_0000; y_t[1] = 32'd4;
    op_t[2] = 2'b01; x_t[2] = 32'h0000_0001; y_t[2] = 32'd31;
    op_t[3] = 2'b01; x_t[3] = 32'h0000_0001; y_t[3] = 32'd32;
    op_t[4] = 2'b00; x_t[4] = 32'hDEAD_BEEF; y_t[4] = 32'hFFFF_FFFF;
    op_t[5] = 2'b10; x_t[5] = 32'h8000_0001; y_t[5] = 32'hFFFF_FFFF;
    op_t[6] = 2'b10; x_t[6] = 32'h7FFF_FFFF; y_t[6] = 32'd40;
    op_t[7] = 2'b11; x_t[7] = 32'h1234_5678; y_t[7] = 32'hFFFF_FFFF;

    // Reset, then idle with no valids.
    do_reset(3);
    repeat (10) begin
      @(negedge clk);
      check("idle_resp_valid", resp_valid, 0);
      check("idle_resp_Z", resp_Z, 0);
    end
    @(posedge clk); #1;

    // Directed shift cases on requester 0.
    for (int i = 0; i < 8; i++) issue(1'b0, op_t[i], x_t[i], y_t[i]);
    wait_idle();

    // Both requesters valid continuously: grants alternate from 0.
    @(posedge clk); #1;
    do_reset(2);
    rand_req(1'b0); rand_req(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    accepts = 0; last_acc = 0;
    for (int i = 0; i < 60 && accepts < 6; i++) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      if (a0 || a1) begin
        check("rr_order", a1, accepts % 2);
        if (accepts > 0) check("issue_interval", cyc + 1 - last_acc, 3);
        last_acc = cyc + 1;
        accepts++;
      end
      @(posedge clk); #1;
      if (a0) rand_req(1'b0);
      if (a1) rand_req(1'b1);
    end
    check("rr_services", accepts, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    // Backpressure with a pending request on requester 1.
    @(posedge clk); #1;
    resp_ready = 1'b0;
    issue(1'b0, 2'b10, 32'hF0F0_1234, 32'd7);
    rand_req(1'b1);
    req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_req1_ready", req1_ready, 0);
      check("bp_resp_valid", resp_valid, 1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_accept_after_release", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset while a request is in EXEC; contention afterwards goes to req0.
    @(posedge clk); #1;
    issue(1'b0, 2'b01, 32'hA5A5_A5A5, 32'd3);
    rst = 1'b1;
    rand_req(1'b0); rand_req(1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = 0; d1 = 0;
    for (int i = 0; i < 30 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("post_reset_grant0", req0_ready, 1);
        check("post_reset_grant1", req1_ready, 0);
      end
      a0 = req0_ready; a1 = req1_ready;
      @(posedge clk); #1;
      if (a0) begin req0_valid = 1'b0; d0 = 1; end
      if (a1) begin req1_valid = 1'b0; d1 = 1; end
    end
    check("post_reset_both_served", {d0, d1}, 2'b11);
    wait_idle();

    // Randomized traffic with random backpressure and withdrawn requests.
    @(posedge clk); #1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      resp_ready = ($urandom_range(0, 3) != 0);
      if (a0) req0_valid = 1'b0;
      else if (req0_valid && $urandom_range(0, 15) == 0) req0_valid = 1'b0;
      else if (!req0_valid && $urandom_range(0, 2) == 0) begin
        rand_req(1'b0); req0_valid = 1'b1;
      end
      if (a1) req1_valid = 1'b0;
      else if (req1_valid && $urandom_range(0, 15) == 0) req1_valid = 1'b0;
      else if (!req1_valid && $urandom_range(0, 2) == 0) begin
        rand_req(1'b1); req1_valid = 1'b1;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of stimulus expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
